// File: rtl/jfpjc_pkg.sv
// Shared constants and state type for the JPEG bit packer.
package jfpjc_pkg;

    localparam int unsigned MAX_CODE_LEN = 27;
    localparam int unsigned WORD_WIDTH   = 32;
    localparam int unsigned FILL_WIDTH   = 6;
    localparam int unsigned ACC_WIDTH    = 64;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } bit_packer_state_t;

endpackage

// File: rtl/jpeg_bit_packer_byte_lane_swap.sv
// Maps an MSB-first 32-bit stream slice into adapter byte order (stream byte k in lane k).
module byte_lane_swap
    import jfpjc_pkg::*;
(
    input  logic [WORD_WIDTH-1:0] stream,
    output logic [WORD_WIDTH-1:0] lanes
);

    always_comb begin
        lanes = '0;
        for (int unsigned i = 0; i < WORD_WIDTH / 8; i++) begin
            lanes[8*i +: 8] = stream[WORD_WIDTH-1-8*i -: 8];
        end
    end

endmodule

// File: rtl/jpeg_bit_packer.sv
// Packs variable-length codes into MSB-first 32-bit JPEG words with 1-padded flush.
// Optional JPEG_BIT_PACKER_WORD_COUNT_EN adds a 16-bit emitted-word counter output.
module jpeg_bit_packer
    import jfpjc_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  code_valid,
    input  logic [31:0]           code,
    input  logic [4:0]            code_len,
    input  logic                  flush,
    output logic                  busy,
    output logic                  flush_done,
    output logic                  data_out_valid,
`ifdef JPEG_BIT_PACKER_WORD_COUNT_EN
    output logic [15:0]           word_count,
`endif
    output logic [WORD_WIDTH-1:0] data_out
);

    bit_packer_state_t state, next_state;

    logic [ACC_WIDTH-1:0]  acc, acc_next, appended;
    logic [FILL_WIDTH-1:0] fill, fill_next, total;
    logic [4:0]            len_eff;
    logic [31:0]           masked;
    logic [6:0]            shamt;
    logic                  in_run, flush_req;
    logic                  emit, done_next;
    logic [WORD_WIDTH-1:0] stream_slice, lanes;

    assign in_run    = (state == RUN);
    assign flush_req = in_run && flush;
    assign len_eff   = (in_run && code_valid) ? code_len : 5'd0;
    assign masked    = code & ((32'd1 << len_eff) - 32'd1);
    // Valid bits sit at the top of the accumulator; new bits land just below them.
    assign shamt     = 7'd64 - {1'b0, fill} - {2'b00, len_eff};
    assign appended  = acc | ({32'b0, masked} << shamt);
    assign total     = fill + {1'b0, len_eff};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            RUN:     if (flush_req && total > 6'd32) next_state = DRAIN;
            DRAIN:   next_state = RUN;
            default: next_state = RUN;
        endcase
    end

    always_comb begin
        acc_next     = acc;
        fill_next    = fill;
        emit         = 1'b0;
        done_next    = 1'b0;
        stream_slice = appended[63:32];
        case (state)
            RUN: begin
                acc_next  = appended;
                fill_next = total;
                if (flush_req) begin
                    done_next = (total <= 6'd32);
                    if (total == 6'd0) begin
                        emit = 1'b0;
                    end else if (total < 6'd32) begin
                        emit         = 1'b1;
                        stream_slice = appended[63:32] | ('1 >> total[4:0]);
                        acc_next     = '0;
                        fill_next    = '0;
                    end else if (total == 6'd32) begin
                        emit      = 1'b1;
                        acc_next  = '0;
                        fill_next = '0;
                    end else begin
                        emit      = 1'b1;
                        acc_next  = {appended[31:0], 32'b0};
                        fill_next = total - 6'd32;
                    end
                end else if (total >= 6'd32) begin
                    emit      = 1'b1;
                    acc_next  = {appended[31:0], 32'b0};
                    fill_next = total - 6'd32;
                end
            end
            DRAIN: begin
                emit         = 1'b1;
                done_next    = 1'b1;
                stream_slice = acc[63:32] | ('1 >> fill[4:0]);
                acc_next     = '0;
                fill_next    = '0;
            end
            default: begin
                acc_next  = '0;
                fill_next = '0;
            end
        endcase
    end

    byte_lane_swap u_swap (
        .stream (stream_slice),
        .lanes  (lanes)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc            <= '0;
            fill           <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            flush_done     <= 1'b0;
            busy           <= 1'b0;
        end else begin
            acc            <= acc_next;
            fill           <= fill_next;
            data_out_valid <= emit;
            flush_done     <= done_next;
            busy           <= (next_state == DRAIN);
            if (emit) data_out <= lanes;
        end
    end

`ifdef JPEG_BIT_PACKER_WORD_COUNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word_count <= '0;
        end else if (emit) begin
            word_count <= word_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// Self-checking bench for jpeg_bit_packer against a bit-queue stream model.
module tb_jpeg_bit_packer;

    logic        clock = 1'b0;
    logic        reset;
    logic        code_valid;
    logic [31:0] code;
    logic [4:0]  code_len;
    logic        flush;
    logic        busy;
    logic        flush_done;
    logic        data_out_valid;
    logic [31:0] data_out;
`ifdef JPEG_BIT_PACKER_WORD_COUNT_EN
    logic [15:0] word_count;
`endif

    jpeg_bit_packer dut (
        .clock          (clock),
        .reset          (reset),
        .code_valid     (code_valid),
        .code           (code),
        .code_len       (code_len),
        .flush          (flush),
        .busy           (busy),
        .flush_done     (flush_done),
        .data_out_valid (data_out_valid),
`ifdef JPEG_BIT_PACKER_WORD_COUNT_EN
        .word_count     (word_count),
`endif
        .data_out       (data_out)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    bit          q[$];
    bit          drain_pending;
    logic [31:0] exp_data;
    bit          exp_valid, exp_done, exp_busy;
    logic [15:0] exp_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Stream byte k goes to lane k; first bit of each byte is its MSB.
    function automatic logic [31:0] pop_word();
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 4; k++)
            for (int b = 0; b < 8; b++)
                w[8*k+7-b] = q.pop_front();
        return w;
    endfunction

    task automatic model_clear();
        q.delete();
        drain_pending = 0;
        exp_count     = '0;
    endtask

    task automatic step(input bit cv, input logic [31:0] c, input int unsigned len, input bit fl);
        code_valid = cv;
        code       = c;
        code_len   = len[4:0];
        flush      = fl;
        exp_valid  = 0;
        exp_done   = 0;
        exp_busy   = 0;
        if (drain_pending) begin
            exp_data      = pop_word();
            exp_valid     = 1;
            exp_done      = 1;
            drain_pending = 0;
        end else begin
            if (cv)
                for (int i = int'(len) - 1; i >= 0; i--) q.push_back(c[i]);
            if (fl) begin
                if (q.size() == 0) begin
                    exp_done = 1;
                end else if (q.size() <= 32) begin
                    while (q.size() < 32) q.push_back(1'b1);
                    exp_data  = pop_word();
                    exp_valid = 1;
                    exp_done  = 1;
                end else begin
                    exp_data  = pop_word();
                    exp_valid = 1;
                    while (q.size() < 32) q.push_back(1'b1);
                    drain_pending = 1;
                    exp_busy      = 1;
                end
            end else if (q.size() >= 32) begin
                exp_data  = pop_word();
                exp_valid = 1;
            end
        end
        if (exp_valid) exp_count = exp_count + 16'd1;
        @(posedge clock);
        #1;
        check("valid", {31'b0, data_out_valid}, {31'b0, exp_valid});
        check("busy", {31'b0, busy}, {31'b0, exp_busy});
        check("flush_done", {31'b0, flush_done}, {31'b0, exp_done});
        if (exp_valid) check("data", data_out, exp_data);
`ifdef JPEG_BIT_PACKER_WORD_COUNT_EN
        check("word_count", {16'b0, word_count}, {16'b0, exp_count});
`endif
        code_valid = 0;
        flush      = 0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, {31'b0, data_out_valid}, 32'd0);
        check({tag, "_data"}, data_out, 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_done"}, {31'b0, flush_done}, 32'd0);
`ifdef JPEG_BIT_PACKER_WORD_COUNT_EN
        check({tag, "_count"}, {16'b0, word_count}, 32'd0);
`endif
    endtask

    initial begin
        reset      = 1;
        code_valid = 0;
        code       = '0;
        code_len   = '0;
        flush      = 0;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        check_zero_outputs("reset");
        reset = 0;

        // Four bytes form one word the cycle after the fourth
        step(1, 32'h12, 8, 0);
        step(1, 32'h34, 8, 0);
        step(1, 32'h56, 8, 0);
        check("four_no_word", {31'b0, data_out_valid}, 32'd0);
        step(1, 32'h78, 8, 0);
        check("four_word", data_out, 32'h78563412);

        step(1, 32'h0000001, 27, 0);
        step(1, 32'h15, 5, 0);
        check("len27_len5", data_out, 32'h35000000);

        step(1, 32'b101, 3, 0);
        step(0, 32'h0, 0, 1);
        check("flush3_data", data_out, 32'hFFFFFFBF);
        check("flush3_done", {31'b0, flush_done}, 32'd1);

        // Flush with f>32 drains, and a code offered while busy is dropped
        step(1, $urandom, 20, 0);
        step(1, $urandom, 20, 1);
        check("drain_busy", {31'b0, busy}, 32'd1);
        step(1, 32'hFF, 8, 0);
        check("drain_done", {31'b0, flush_done}, 32'd1);
        step(1, 32'hC3, 8, 1);
        check("after_drain", data_out, 32'hFFFFFFC3);

        step(1, 32'hABCD, 16, 0);
        step(1, 32'h1234, 16, 1);
        check("flush32", data_out, 32'h3412CDAB);

        step(0, 32'h0, 0, 1);
        check("flush_empty_done", {31'b0, flush_done}, 32'd1);

        // Asynchronous reset mid-stream discards partial data
        step(1, $urandom, 12, 0);
        reset = 1;
        #1;
        check_zero_outputs("async_reset");
        @(posedge clock);
        #1;
        check_zero_outputs("mid_reset");
        reset = 0;
        model_clear();
        step(1, 32'hAB, 8, 1);
        check("post_reset", data_out, 32'hFFFFFFAB);

        for (int i = 0; i < 8; i++) step(1, 32'hFFFFFFF0, 4, 0);
        check("masked", data_out, 32'h00000000);
        check("masked_valid", {31'b0, data_out_valid}, 32'd1);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 27),
                 $urandom_range(0, 24) == 0);
        end
        step(0, 32'h0, 0, 1);
        step(0, 32'h0, 0, 1);
        step(0, 32'h0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
